// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 scancode decoder.
//   - prefix / status byte constants seen on the keyboard-to-host stream
//   - decoder FSM state encoding
//   - 10-bit key event layout {code, ext, brk}
//   - pressed-bitmap index helper (used when PS2_REPEAT_FILTER_EN is defined)
package ps2_pkg;

   localparam int unsigned EV_W = 10;

   localparam logic [7:0] PS2_EXT      = 8'hE0;
   localparam logic [7:0] PS2_BREAK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE    = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_ECHO     = 8'hEE;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
   localparam logic [7:0] PS2_ERR0     = 8'h00;
   localparam logic [7:0] PS2_ERR1     = 8'hFF;

   // E0 12 / E0 59 are fake shifts emitted around extended keys
   localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;
   localparam logic [7:0] PS2_PAUSE_CODE  = 8'h77;
   localparam logic [7:0] PS2_F7          = 8'h83;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_E0   = 3'd1,
      ST_F0   = 3'd2,
      ST_E0F0 = 3'd3,
      ST_SKIP = 3'd4
   } ps2_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_event_t;

   // F7 (83) is the only set-2 code above 7F; fold it onto the unused slot 02
   function automatic logic [7:0] key_index(input logic [7:0] code, input logic ext);
      logic [6:0] low;
      low = (code == PS2_F7) ? 7'h02 : code[6:0];
      return {ext, low};
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Register-based show-ahead FIFO for decoded key events.
// Ports: clk, rstn (async active-low), push/wdata, pop, rdata (head entry),
//        full, empty, level (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key event decoder.
// Strips E0/F0/E1 prefixes and keyboard status bytes, queues {code,ext,brk}
// events in a show-ahead FIFO with a valid/ready handshake.
// Ports: clk, rstn (async active-low), rx_data/rx_valid (bytes from ps2host),
//        ev_code/ev_ext/ev_break/ev_valid/ev_ready (event handshake),
//        fifo_level, overflow (sticky) / clr_overflow, bat_ok (pulse).
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic repeats
// and orphan breaks using a 256-entry pressed-key bitmap.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PAUSE_LEN  = 7
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_break,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          bat_ok
);

   localparam int unsigned CNT_W = $clog2(PAUSE_LEN + 1);

   ps2_state_t     state;
   logic [CNT_W-1:0] cnt;

   ps2_event_t dec_ev;
   logic       dec_valid;
   logic       dec_pause;
   logic       dec_err;
   logic       dec_bat;
   logic       suppress;
   logic       push;
   logic       pop;
   logic       drop;
   logic       fifo_full;
   logic       fifo_empty;
   ps2_event_t head;

   // Byte classification in the current state; produces at most one event
   always_comb begin
      dec_ev    = '0;
      dec_valid = 1'b0;
      dec_pause = 1'b0;
      dec_err   = 1'b0;
      dec_bat   = 1'b0;
      if (rx_valid) begin
         case (state)
            ST_IDLE: begin
               case (rx_data)
                  PS2_EXT, PS2_BREAK, PS2_PAUSE,
                  PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_BAT_FAIL: ;
                  PS2_BAT_OK:         dec_bat = 1'b1;
                  PS2_ERR0, PS2_ERR1: dec_err = 1'b1;
                  default: begin
                     dec_ev    = '{code: rx_data, ext: 1'b0, brk: 1'b0};
                     dec_valid = 1'b1;
                  end
               endcase
            end
            ST_E0: begin
               case (rx_data)
                  PS2_BREAK, PS2_FAKE_LSHIFT, PS2_FAKE_RSHIFT, PS2_EXT, PS2_PAUSE: ;
                  default: begin
                     dec_ev    = '{code: rx_data, ext: 1'b1, brk: 1'b0};
                     dec_valid = 1'b1;
                  end
               endcase
            end
            ST_F0: begin
               case (rx_data)
                  PS2_EXT, PS2_BREAK, PS2_PAUSE: ;
                  default: begin
                     dec_ev    = '{code: rx_data, ext: 1'b0, brk: 1'b1};
                     dec_valid = 1'b1;
                  end
               endcase
            end
            ST_E0F0: begin
               case (rx_data)
                  PS2_FAKE_LSHIFT, PS2_FAKE_RSHIFT, PS2_EXT, PS2_BREAK, PS2_PAUSE: ;
                  default: begin
                     dec_ev    = '{code: rx_data, ext: 1'b1, brk: 1'b1};
                     dec_valid = 1'b1;
                  end
               endcase
            end
            ST_SKIP: begin
               // Pause sequence has no break; report it once as an extended make
               if (cnt == CNT_W'(1)) begin
                  dec_ev    = '{code: PS2_PAUSE_CODE, ext: 1'b1, brk: 1'b0};
                  dec_valid = 1'b1;
                  dec_pause = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic [255:0] pressed;
   logic [7:0]   key_idx;
   logic         is_pressed;

   assign key_idx    = key_index(dec_ev.code, dec_ev.ext);
   assign is_pressed = pressed[key_idx];
   // Pause never sends a break, so it bypasses the filter
   assign suppress   = ~dec_pause & (dec_ev.brk ? ~is_pressed : is_pressed);

   // Pressed-key bitmap; BAT completion means the keyboard restarted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pressed <= '0;
      end else if (dec_bat) begin
         pressed <= '0;
      end else if (dec_valid && !suppress && !dec_pause) begin
         pressed[key_idx] <= ~dec_ev.brk;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign push = dec_valid & ~suppress;
   assign pop  = ev_valid & ev_ready;
   assign drop = push & fifo_full & ~pop;

   // Prefix tracking FSM, pause skip counter and status outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bat_ok   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         bat_ok <= dec_bat;
         if (dec_err || drop)   overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;

         if (rx_valid) begin
            case (state)
               ST_IDLE: begin
                  case (rx_data)
                     PS2_EXT:   state <= ST_E0;
                     PS2_BREAK: state <= ST_F0;
                     PS2_PAUSE: begin
                        state <= ST_SKIP;
                        cnt   <= CNT_W'(PAUSE_LEN);
                     end
                     default:   state <= ST_IDLE;
                  endcase
               end
               ST_E0:   state <= (rx_data == PS2_BREAK) ? ST_E0F0 : ST_IDLE;
               ST_F0:   state <= ST_IDLE;
               ST_E0F0: state <= ST_IDLE;
               ST_SKIP: begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   ps2_event_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .wdata (dec_ev),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign ev_valid = ~fifo_empty;
   assign ev_code  = head.code;
   assign ev_ext   = head.ext;
   assign ev_break = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares on every accepted handshake.
module tb_ps2_scancode_decoder;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [$clog2(DEPTH):0] fifo_level;
   logic       overflow;
   logic       clr_overflow = 1'b0;
   logic       bat_ok;

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .PAUSE_LEN(7)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .ev_code      (ev_code),
      .ev_ext       (ev_ext),
      .ev_break     (ev_break),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .bat_ok       (bat_ok)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head event must match the oldest expectation
   always @(negedge clk) begin
      if (rstn && ev_valid && ev_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got %0h expected none", {ev_code, ev_ext, ev_break});
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if ({ev_code, ev_ext, ev_break} !== e) begin
               bad++;
               $display("FAIL event: got %0h expected %0h", {ev_code, ev_ext, ev_break}, e);
            end
         end
      end
   end

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
      exp_q.push_back({code, ext, brk});
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      ev_ready = 1'b1;
      while (ev_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ev_ready = 1'b0;
      check("drain_timeout", int'(ev_valid), 0);
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(ev_valid), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_bat", int'(bat_ok), 0);
      check("rst_code", int'(ev_code), 0);
      rstn = 1'b1;

      // 1: plain make and break, one-cycle latency
      expect_ev(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      check("t1_valid", int'(ev_valid), 1);
      check("t1_level", int'(fifo_level), 1);
      expect_ev(8'h1C, 1'b0, 1'b1);
      send(8'hF0);
      check("t1_level_prefix", int'(fifo_level), 1);
      send(8'h1C);
      check("t1_level2", int'(fifo_level), 2);
      drain();

      // 2: extended make/break, fake shift swallowed
      expect_ev(8'h75, 1'b1, 1'b0);
      send(8'hE0); send(8'h75);
      expect_ev(8'h75, 1'b1, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h12);
      check("t2_level", int'(fifo_level), 2);
      drain();

      // 3: pause sequence gives one event, then normal decode
      expect_ev(8'h77, 1'b1, 1'b0);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0);
      check("t3_level_before", int'(fifo_level), 0);
      send(8'h77);
      check("t3_level", int'(fifo_level), 1);
      expect_ev(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      check("t3_level2", int'(fifo_level), 2);
      drain();

      // status bytes ignored, 00 sets overflow
      send(8'hFA); send(8'hEE);
      check("ign_level", int'(fifo_level), 0);
      send(8'h00);
      check("err_ovf", int'(overflow), 1);
      check("err_level", int'(fifo_level), 0);
      @(posedge clk); #1; clr_overflow = 1'b1;
      @(posedge clk); #1; clr_overflow = 1'b0;
      check("err_clr", int'(overflow), 0);

      // 4: overflow with FIFO full; set beats clear
      expect_ev(8'h15, 1'b0, 1'b0);
      expect_ev(8'h16, 1'b0, 1'b0);
      expect_ev(8'h1A, 1'b0, 1'b0);
      expect_ev(8'h1B, 1'b0, 1'b0);
      send(8'h15); send(8'h16); send(8'h1A); send(8'h1B);
      check("t4_ovf_pre", int'(overflow), 0);
      send(8'h1D);
      check("t4_level", int'(fifo_level), 4);
      check("t4_ovf", int'(overflow), 1);
      check("t4_head", int'({ev_code, ev_ext, ev_break}), int'({8'h15, 1'b0, 1'b0}));
      @(posedge clk); #1;
      rx_data = 8'h22; rx_valid = 1'b1; clr_overflow = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; clr_overflow = 1'b0;
      check("t4_set_wins", int'(overflow), 1);
      @(posedge clk); #1; clr_overflow = 1'b1;
      @(posedge clk); #1; clr_overflow = 1'b0;
      check("t4_clr", int'(overflow), 0);

      // 5: push and pop together while full
      @(posedge clk); #1;
      rx_data = 8'h21; rx_valid = 1'b1; ev_ready = 1'b1;
      expect_ev(8'h21, 1'b0, 1'b0);
      @(posedge clk); #1;
      rx_valid = 1'b0; ev_ready = 1'b0;
      check("t5_level", int'(fifo_level), 4);
      check("t5_ovf", int'(overflow), 0);
      check("t5_head", int'(ev_code), 8'h16);
      drain();

      // 6: BAT pulse, then repeat filter behaviour
      send(8'hAA);
      check("t6_bat", int'(bat_ok), 1);
      @(posedge clk); #1;
      check("t6_bat_pulse", int'(bat_ok), 0);
      check("t6_bat_level", int'(fifo_level), 0);
      expect_ev(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
      expect_ev(8'h1C, 1'b0, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0);
`endif
      send(8'h1C); send(8'h1C);
      expect_ev(8'h1C, 1'b0, 1'b1);
      send(8'hF0); send(8'h1C);
      drain();

      // reset mid-sequence discards the pending E0
      send(8'hE0);
      @(posedge clk); #1; rstn = 1'b0;
      @(posedge clk); #1; rstn = 1'b1;
      check("rst2_level", int'(fifo_level), 0);
      expect_ev(8'h75, 1'b0, 1'b0);
      send(8'h75);
      check("rst2_valid", int'(ev_valid), 1);
      drain();

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
